// File: rtl/rs_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_queue_pkg
//  Description : Shared defaults and opcode encodings for the mul/div
//                reservation station.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_issue_queue_pkg;

    localparam int RS_DEPTH  = 8;
    localparam int RS_XLEN   = 32;
    localparam int RS_TAG_W  = 5;
    localparam int RS_OP_W   = 3;
    localparam int RS_NUM_WB = 3;

    typedef enum logic [RS_OP_W-1:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } rs_op_e;

endpackage
`default_nettype wire

// File: rtl/rs_issue_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_queue_if
//  Description : Dispatch, writeback, issue and flush signals of the RS.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rs_issue_queue_if #(
    parameter int DEPTH  = rs_issue_queue_pkg::RS_DEPTH,
    parameter int XLEN   = rs_issue_queue_pkg::RS_XLEN,
    parameter int TAG_W  = rs_issue_queue_pkg::RS_TAG_W,
    parameter int OP_W   = rs_issue_queue_pkg::RS_OP_W,
    parameter int NUM_WB = rs_issue_queue_pkg::RS_NUM_WB
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [OP_W-1:0]         in_op;
    logic [TAG_W-1:0]        in_tag;
    logic                    in_a_dep;
    logic [XLEN-1:0]         in_a;
    logic                    in_b_dep;
    logic [XLEN-1:0]         in_b;
    logic [NUM_WB-1:0]       wb_en;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_val;
    logic                    iss_valid;
    logic                    iss_ready;
    logic [OP_W-1:0]         iss_op;
    logic [TAG_W-1:0]        iss_tag;
    logic [XLEN-1:0]         iss_a;
    logic [XLEN-1:0]         iss_b;
    logic [CNT_W-1:0]        count;

    modport master (
        output flush, in_valid, in_op, in_tag, in_a_dep, in_a, in_b_dep, in_b,
               wb_en, wb_tag, wb_val, iss_ready,
        input  in_ready, iss_valid, iss_op, iss_tag, iss_a, iss_b, count
    );

    modport slave (
        input  flush, in_valid, in_op, in_tag, in_a_dep, in_a, in_b_dep, in_b,
               wb_en, wb_tag, wb_val, iss_ready,
        output in_ready, iss_valid, iss_op, iss_tag, iss_a, iss_b, count
    );

endinterface
`default_nettype wire

// File: rtl/rs_issue_queue_age_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_queue_age_matrix
//  Description : Older-than bit matrix; grants the oldest requesting entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_queue_age_matrix
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] grant_o,
    output logic             any_grant_o
);

    // older_q[i][j] set: entry i was allocated before entry j
    logic [DEPTH-1:0][DEPTH-1:0] older_q;

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            older_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_i[j] && (i != j)) begin
                        older_q[i][j] <= 1'b1;
                    end else if (alloc_i[i] || free_i[i] || free_i[j]) begin
                        older_q[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_o = req_i;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (req_i[j] && older_q[j][i]) begin
                    grant_o[i] = 1'b0;
                end
            end
        end
    end

    assign any_grant_o = |grant_o;

endmodule
`default_nettype wire

// File: rtl/rs_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_queue
//  Description : Reservation station for multi-cycle units with operand
//                wakeup, oldest-ready issue, dispatch bypass and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH  = RS_DEPTH,
    parameter int XLEN   = RS_XLEN,
    parameter int TAG_W  = RS_TAG_W,
    parameter int OP_W   = RS_OP_W,
    parameter int NUM_WB = RS_NUM_WB
) (
    input  logic          clk,
    input  logic          rst,
    rs_issue_queue_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] a_dep_q;
    logic [DEPTH-1:0] b_dep_q;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [XLEN-1:0]  a_q   [DEPTH];
    logic [XLEN-1:0]  b_q   [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             iss_valid_q;
    logic [OP_W-1:0]  iss_op_q;
    logic [TAG_W-1:0] iss_tag_q;
    logic [XLEN-1:0]  iss_a_q;
    logic [XLEN-1:0]  iss_b_q;

    logic [DEPTH-1:0][NUM_WB-1:0] a_hit;
    logic [DEPTH-1:0][NUM_WB-1:0] b_hit;
    logic [NUM_WB-1:0]            in_a_hit;
    logic [NUM_WB-1:0]            in_b_hit;

    generate
        for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
            assign in_a_hit[k] = bus.wb_en[k] && (bus.wb_tag[k*TAG_W +: TAG_W] == bus.in_a[TAG_W-1:0]);
            assign in_b_hit[k] = bus.wb_en[k] && (bus.wb_tag[k*TAG_W +: TAG_W] == bus.in_b[TAG_W-1:0]);
            for (genvar i = 0; i < DEPTH; i++) begin : g_ent
                assign a_hit[i][k] = bus.wb_en[k] && (bus.wb_tag[k*TAG_W +: TAG_W] == a_q[i][TAG_W-1:0]);
                assign b_hit[i][k] = bus.wb_en[k] && (bus.wb_tag[k*TAG_W +: TAG_W] == b_q[i][TAG_W-1:0]);
            end
        end
    endgenerate

    // Walk buses high to low so the lowest matching bus index wins.
    logic [XLEN-1:0] a_wb_val [DEPTH];
    logic [XLEN-1:0] b_wb_val [DEPTH];
    logic [XLEN-1:0] in_a_wb_val;
    logic [XLEN-1:0] in_b_wb_val;

    always_comb begin
        in_a_wb_val = '0;
        in_b_wb_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            a_wb_val[i] = '0;
            b_wb_val[i] = '0;
        end
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (in_a_hit[k]) in_a_wb_val = bus.wb_val[k*XLEN +: XLEN];
            if (in_b_hit[k]) in_b_wb_val = bus.wb_val[k*XLEN +: XLEN];
            for (int i = 0; i < DEPTH; i++) begin
                if (a_hit[i][k]) a_wb_val[i] = bus.wb_val[k*XLEN +: XLEN];
                if (b_hit[i][k]) b_wb_val[i] = bus.wb_val[k*XLEN +: XLEN];
            end
        end
    end

    logic            in_a_rdy;
    logic            in_b_rdy;
    logic [XLEN-1:0] in_a_res;
    logic [XLEN-1:0] in_b_res;

    assign in_a_rdy = !bus.in_a_dep || (|in_a_hit);
    assign in_b_rdy = !bus.in_b_dep || (|in_b_hit);
    assign in_a_res = (bus.in_a_dep && (|in_a_hit)) ? in_a_wb_val : bus.in_a;
    assign in_b_res = (bus.in_b_dep && (|in_b_hit)) ? in_b_wb_val : bus.in_b;

    logic             in_ready;
    logic             in_fire;
    logic             load;
    logic             sel_fire;
    logic             bypass;
    logic             alloc_en;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic             any_grant;
    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] sel_oh;

    assign in_ready  = rst && !bus.flush && (count_q < CNT_W'(DEPTH));
    assign in_fire   = bus.in_valid && in_ready;
    assign load      = rst && !bus.flush && (!iss_valid_q || bus.iss_ready);
    assign ready_vec = valid_q & ~a_dep_q & ~b_dep_q;
    assign sel_fire  = load && any_grant;
    assign bypass    = load && !any_grant && in_fire && in_a_rdy && in_b_rdy;
    assign alloc_en  = in_fire && !bypass;
    // Lowest clear bit of valid_q as a one-hot.
    assign free_oh   = ~valid_q & (valid_q + DEPTH'(1));
    assign alloc_oh  = alloc_en ? free_oh : '0;
    assign sel_oh    = sel_fire ? grant : '0;
    assign count_d   = count_q + CNT_W'(alloc_en) - CNT_W'(sel_fire);

    rs_issue_queue_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.flush),
        .alloc_i     (alloc_oh),
        .free_i      (sel_oh),
        .req_i       (ready_vec),
        .grant_o     (grant),
        .any_grant_o (any_grant)
    );

    logic [OP_W-1:0]  sel_op;
    logic [TAG_W-1:0] sel_tag;
    logic [XLEN-1:0]  sel_a;
    logic [XLEN-1:0]  sel_b;

    always_comb begin
        sel_op  = '0;
        sel_tag = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_op  = op_q[i];
                sel_tag = tag_q[i];
                sel_a   = a_q[i];
                sel_b   = b_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    valid_q[i] <= 1'b1;
                    op_q[i]    <= bus.in_op;
                    tag_q[i]   <= bus.in_tag;
                    a_dep_q[i] <= !in_a_rdy;
                    a_q[i]     <= in_a_res;
                    b_dep_q[i] <= !in_b_rdy;
                    b_q[i]     <= in_b_res;
                end else begin
                    if (sel_oh[i]) valid_q[i] <= 1'b0;
                    if (a_dep_q[i] && (|a_hit[i])) begin
                        a_dep_q[i] <= 1'b0;
                        a_q[i]     <= a_wb_val[i];
                    end
                    if (b_dep_q[i] && (|b_hit[i])) begin
                        b_dep_q[i] <= 1'b0;
                        b_q[i]     <= b_wb_val[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            iss_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            count_q <= count_d;
            if (load) begin
                if (sel_fire) begin
                    iss_valid_q <= 1'b1;
                    iss_op_q    <= sel_op;
                    iss_tag_q   <= sel_tag;
                    iss_a_q     <= sel_a;
                    iss_b_q     <= sel_b;
                end else if (bypass) begin
                    iss_valid_q <= 1'b1;
                    iss_op_q    <= bus.in_op;
                    iss_tag_q   <= bus.in_tag;
                    iss_a_q     <= in_a_res;
                    iss_b_q     <= in_b_res;
                end else begin
                    iss_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.iss_valid = iss_valid_q;
    assign bus.iss_op    = iss_op_q;
    assign bus.iss_tag   = iss_tag_q;
    assign bus.iss_a     = iss_a_q;
    assign bus.iss_b     = iss_b_q;
    assign bus.count     = count_q;

endmodule
`default_nettype wire
